// File: rtl/barrel_shift_seq.sv
// Sequencer in front of a combinational rotate-left barrel shifter. It splits a large rotate amount
// into passes of at most MAX_STEP and loops each shifter result back through the work register.
module barrel_shift_seq #(
    parameter int WIDTH    = 4,
    parameter int SEL_W    = 2,
    parameter int AMT_W    = 4,
    parameter int MAX_STEP = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [AMT_W-1:0] in_amt,
    output logic [WIDTH-1:0] sh_data_in,
    output logic [SEL_W-1:0] sh_S,
    input  logic [WIDTH-1:0] sh_data_out,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             busy
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [AMT_W-1:0] MAX_STEP_A = AMT_W'(MAX_STEP);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] work_q, work_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic [AMT_W-1:0] rem_q, rem_d;
    logic [AMT_W-1:0] step;

    // step never exceeds rem, so rem - step cannot wrap
    always_comb begin
        step = (rem_q < MAX_STEP_A) ? rem_q : MAX_STEP_A;
    end

    always_comb begin
        state_d    = state_q;
        work_d     = work_q;
        rem_d      = rem_q;
        out_data_d = out_data_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    work_d = in_data;
                    rem_d  = in_amt;
                    if (in_amt == '0) begin
                        out_data_d = in_data;
                        state_d    = S_DONE;
                    end else begin
                        state_d = S_RUN;
                    end
                end
            end
            S_RUN: begin
                work_d = sh_data_out;
                rem_d  = rem_q - step;
                if (rem_q == step) begin
                    out_data_d = sh_data_out;
                    state_d    = S_DONE;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            work_q     <= '0;
            rem_q      <= '0;
            out_data_q <= '0;
        end else begin
            state_q    <= state_d;
            work_q     <= work_d;
            rem_q      <= rem_d;
            out_data_q <= out_data_d;
        end
    end

    always_comb begin
        in_ready   = (state_q == S_IDLE);
        out_valid  = (state_q == S_DONE);
        busy       = (state_q == S_RUN) || (state_q == S_DONE);
        sh_S       = (state_q == S_RUN) ? SEL_W'(step) : '0;
        sh_data_in = work_q;
        out_data   = out_data_q;
    end

endmodule

// File: tb/tb_barrel_shift_seq.sv
// Directed bench for barrel_shift_seq: a vector table plus hand-written backpressure and reset cases.
module tb_barrel_shift_seq;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] in_data;
    logic [3:0] in_amt;
    logic [3:0] sh_data_in;
    logic [1:0] sh_S;
    logic [3:0] sh_data_out;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] out_data;
    logic       busy;

    int checks = 0;
    int errors = 0;

    barrel_shift_seq dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .in_amt     (in_amt),
        .sh_data_in (sh_data_in),
        .sh_S       (sh_S),
        .sh_data_out(sh_data_out),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    // shifter stand-in: rotate left by sh_S
    logic [7:0] dbl;
    assign dbl         = {sh_data_in, sh_data_in} << sh_S;
    assign sh_data_out = dbl[7:4];

    typedef struct {
        logic [3:0] data;
        logic [3:0] amt;
        logic [3:0] exp;
        int         lat;
    } vec_t;

    vec_t       vecs[10];
    logic [1:0] s_tr[16];
    logic [3:0] d_tr[16];
    int         runs;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Issue one request, then watch until out_valid. Returns the latency in cycles.
    task automatic run_req(input logic [3:0] data, input logic [3:0] amt, input bit junk,
                           output int cycles);
        @(negedge clk);
        check("in_ready_before_req", in_ready, 1);
        in_valid = 1'b1;
        in_data  = data;
        in_amt   = amt;
        @(posedge clk);
        #1;
        in_valid = junk;
        in_data  = ~data;
        in_amt   = amt + 4'd3;
        cycles   = 0;
        runs     = 0;
        while (cycles < 40) begin
            @(negedge clk);
            cycles++;
            if (out_valid) break;
            check("in_ready_low_in_run", in_ready, 0);
            check("busy_in_run", busy, 1);
            if (runs < 16) begin
                s_tr[runs] = sh_S;
                d_tr[runs] = sh_data_in;
            end
            runs++;
        end
        in_valid = 1'b0;
        check("out_valid_reached", out_valid, 1);
        check("in_ready_low_in_done", in_ready, 0);
        check("sh_S_zero_in_done", sh_S, 0);
        check("busy_in_done", busy, 1);
    endtask

    int cyc;

    initial begin
        vecs[0] = '{4'b1010, 4'd0,  4'b1010, 1};
        vecs[1] = '{4'b1010, 4'd1,  4'b0101, 2};
        vecs[2] = '{4'b1011, 4'd5,  4'b0111, 3};
        vecs[3] = '{4'b1011, 4'd15, 4'b1101, 6};
        vecs[4] = '{4'b1100, 4'd4,  4'b1100, 3};
        vecs[5] = '{4'b0001, 4'd3,  4'b1000, 2};
        vecs[6] = '{4'b0011, 4'd6,  4'b1100, 3};
        vecs[7] = '{4'b0110, 4'd7,  4'b0011, 4};
        vecs[8] = '{4'b1000, 4'd2,  4'b0010, 2};
        vecs[9] = '{4'b0111, 4'd12, 4'b0111, 5};

        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        in_amt    = '0;
        out_ready = 1'b1;
        #12;
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_sh_S", sh_S, 0);
        check("rst_sh_data_in", sh_data_in, 0);
        check("rst_out_data", out_data, 0);
        @(negedge clk);
        rst = 1'b0;

        // table, with junk in_valid held during half the runs
        for (int i = 0; i < 10; i++) begin
            run_req(vecs[i].data, vecs[i].amt, (i % 2) == 1, cyc);
            check($sformatf("vec%0d_out_data", i), out_data, vecs[i].exp);
            check($sformatf("vec%0d_latency", i), cyc, vecs[i].lat);
        end

        // pass-through: no RUN cycle
        run_req(4'b1010, 4'd0, 1'b0, cyc);
        check("c1_runs", runs, 0);
        check("c1_out", out_data, 4'b1010);

        // single pass trace
        run_req(4'b1010, 4'd1, 1'b0, cyc);
        check("c2_runs", runs, 1);
        check("c2_s0", s_tr[0], 2'b01);
        check("c2_d0", d_tr[0], 4'b1010);

        // multi-pass trace
        run_req(4'b1011, 4'd5, 1'b0, cyc);
        check("c3_runs", runs, 2);
        check("c3_s0", s_tr[0], 2'b11);
        check("c3_s1", s_tr[1], 2'b10);
        check("c3_d0", d_tr[0], 4'b1011);
        check("c3_d1", d_tr[1], 4'b1101);
        check("c3_out", out_data, 4'b0111);

        // max amount: five passes of 3
        run_req(4'b1011, 4'd15, 1'b0, cyc);
        check("c4_runs", runs, 5);
        for (int k = 0; k < 5; k++) check($sformatf("c4_s%0d", k), s_tr[k], 2'b11);
        check("c4_out", out_data, 4'b1101);

        // backpressure on the single-pass case
        @(negedge clk);
        out_ready = 1'b0;
        run_req(4'b1010, 4'd1, 1'b0, cyc);
        check("c5_out", out_data, 4'b0101);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("c5_hold_valid", out_valid, 1);
            check("c5_hold_data", out_data, 4'b0101);
            check("c5_hold_in_ready", in_ready, 0);
        end
        out_ready = 1'b1;
        @(negedge clk);
        check("c5_release_valid", out_valid, 0);
        check("c5_release_in_ready", in_ready, 1);
        check("c5_release_busy", busy, 0);

        // reset during the 2nd RUN cycle of the max-amount case
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = 4'b1011;
        in_amt   = 4'd15;
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(negedge clk);
        check("c6_run1_busy", busy, 1);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("c6_rst_in_ready", in_ready, 1);
        check("c6_rst_out_valid", out_valid, 0);
        check("c6_rst_busy", busy, 0);
        check("c6_rst_sh_S", sh_S, 0);
        check("c6_rst_sh_data_in", sh_data_in, 0);
        check("c6_rst_out_data", out_data, 0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("c6_no_valid", out_valid, 0);
        end
        rst = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            check("c6_idle_after_release", out_valid, 0);
        end
        run_req(4'b1010, 4'd1, 1'b0, cyc);
        check("c6_new_out", out_data, 4'b0101);
        check("c6_new_latency", cyc, 2);

        @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
